seq_0110_ctrl: RTL and testbench
================================

Name: seq_0110_ctrl

Overview:
- Serial sequencing controller for the team's 4-input "0110" detector primitive (output high only for A,B,C,D = 0,1,1,0).
- Accepts a qualified serial bit stream and maintains the 4-bit window that is presented to the detector.
- Runs a Moore FSM that flags each occurrence of the serial pattern 0-1-1-0 and counts matches.
- Sits between a serial source (switch/UART bit stream) and display/LED logic.

Parameters:
- CNT_W, 8, width of the match counter.
- OVERLAP, 1, 1 = a pattern's trailing 0 may begin the next pattern; 0 = detection restarts fresh after each match.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of FSM, window and counter.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on a rising edge only when this is high.
- window  output  4  last four accepted bits; bit3 = oldest (A), bit0 = newest (D). Drives the detector's A,B,C,D.
- match  output  1  registered one-cycle pulse per detected pattern.
- match_cnt  output  CNT_W  number of matches since reset/clr; saturates.
- state  output  2  current FSM state encoding, for debug.

Behaviour:
- Reset: rst high asynchronously forces state=IDLE(2'd0), window=4'b0000, match=0, match_cnt=0. Reset mid-stream discards partial progress; the first bit after release starts from IDLE.
- All other updates occur on the rising edge of clk.
- Priority: rst > clr > din_valid. When clr=1: same values as reset on that edge; din is ignored even if din_valid=1.
- din_valid=0: state, window and match_cnt hold; match=0.
- Window, when din_valid=1: window <= {window[2:0], din}.
- States: IDLE=0 (no prefix), G0=1 (seen 0), G01=2 (seen 01), G011=3 (seen 011).
- Transitions on an accepted bit:
  - IDLE: 0->G0, 1->IDLE.
  - G0: 0->G0, 1->G01.
  - G01: 0->G0, 1->G011.
  - G011: 1->IDLE. 0->match; next state is G0 if OVERLAP=1, IDLE if OVERLAP=0.
- match is registered: set high on the same edge that accepts the completing 0, visible for exactly that following cycle, cleared on the next edge.
- Back-to-back valid bits can raise match on at most every third accepted bit (OVERLAP=1), since a new match needs at least 1-1-0 after the prior one.
- match_cnt increments by 1 on the edge match is set. It holds at 2^CNT_W-1, and match still pulses at saturation.
- Invariant: with OVERLAP=1, whenever match=1, window=4'b0110. The combinational detector fed by window must agree with match on the cycle after the completing bit.
- The reset value window=0000 never produces a false match, and no match is possible before 4 accepted bits.

Test Plan:
- Reset check: assert rst asynchronously between clock edges -> outputs immediately 0/IDLE. Release, then feed 0,1,1,0 with din_valid=1 -> match=1 only in the cycle after the 4th bit; window=0110; match_cnt=1; state=G0.
- Overlap: OVERLAP=1, feed 0110110 -> two match pulses, after bits 4 and 7; match_cnt=2. Same stream with OVERLAP=0 -> one pulse; match_cnt=1.
- Gaps: feed 0,1,1,0 with din_valid=0 for 3 cycles between each bit -> state and window hold during gaps; single match after the 4th valid bit. Near-misses 0111, 1110 and 0100 -> no match; state returns IDLE/G0 per the transition list.
- Clear priority: after 0,1,1, assert clr with din=0 and din_valid=1 -> no match; state=IDLE, window=0000, match_cnt=0.
- Saturation: CNT_W=2, stream 0110 repeated 5 times with OVERLAP=1 -> match pulses 5 times; match_cnt goes 1,2,3,3,3.
- Reset mid-pattern: feed 0,1,1, pulse rst, then feed 0 -> no match; state=G0.

Source files
------------

// File: rtl/seq_0110_ctrl.sv
// rtl/seq_0110_ctrl.sv - serial 0-1-1-0 sequencing controller with window, match pulse and counter
//
// Purpose:
//   Accepts a qualified serial bit stream, keeps the last four accepted bits
//   as the window presented to the 4-input "0110" detector, and runs a Moore
//   FSM that pulses match once per detected 0-1-1-0 and counts matches.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   clr        in   1      synchronous clear of FSM, window and counter
//   din        in   1      serial data bit
//   din_valid  in   1      din is accepted on a rising edge only when high
//   window     out  4      last four accepted bits, [3]=oldest (A) .. [0]=newest (D)
//   match      out  1      registered one-cycle pulse per detected pattern
//   match_cnt  out  CNT_W  matches since reset/clr, saturating
//   state      out  2      current FSM state encoding (debug)

module seq_0110_ctrl #(
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic [3:0]       window,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G01  = 2'd2,
    G011 = 2'd3
  } state_t;

  // With overlap the completing 0 is itself the first bit of the next pattern.
  localparam state_t AFTER_MATCH = (OVERLAP != 0) ? G0 : IDLE;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       window_q, window_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      window_q <= 4'b0000;
      match_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    match_d  = 1'b0;
    cnt_d    = cnt_q;

    if (clr) begin
      state_d  = IDLE;
      window_d = 4'b0000;
      cnt_d    = '0;
    end else if (din_valid) begin
      window_d = {window_q[2:0], din};
      unique case (state_q)
        IDLE: state_d = din ? IDLE : G0;
        G0:   state_d = din ? G01  : G0;
        G01:  state_d = din ? G011 : G0;
        G011: begin
          if (din) begin
            state_d = IDLE;
          end else begin
            state_d = AFTER_MATCH;
            match_d = 1'b1;
            // Counter sticks at all-ones; match still pulses at saturation.
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign window    = window_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seq_0110_ctrl.sv
// tb/tb_seq_0110_ctrl.sv - self-checking bench for seq_0110_ctrl
module tb_seq_0110_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  // a: OVERLAP=1 CNT_W=8, b: OVERLAP=0 CNT_W=8, c: OVERLAP=1 CNT_W=2
  logic [3:0] win_a, win_b, win_c;
  logic       m_a, m_b, m_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [1:0] st_a, st_b, st_c;

  int passed = 0;
  int total  = 0;

  seq_0110_ctrl #(.CNT_W(8), .OVERLAP(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .window(win_a), .match(m_a), .match_cnt(cnt_a), .state(st_a)
  );

  seq_0110_ctrl #(.CNT_W(8), .OVERLAP(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .window(win_b), .match(m_b), .match_cnt(cnt_b), .state(st_b)
  );

  seq_0110_ctrl #(.CNT_W(2), .OVERLAP(1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
    .window(win_c), .match(m_c), .match_cnt(cnt_c), .state(st_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       din;
    logic       vld;
    logic [3:0] win;
    logic       m;
    logic [1:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic d, input logic v,
                     input logic [3:0] w, input logic m, input logic [1:0] s,
                     input logic [7:0] n);
    vec_t t;
    t.clr = c; t.din = d; t.vld = v; t.win = w; t.m = m; t.st = s; t.cnt = n;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic c, input logic d, input logic v);
    @(negedge clk);
    clr = c; din = d; din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] bits7;
  logic [3:0] pat;
  logic [1:0] exp_c [5];

  initial begin
    // Reset state while rst is held from time zero.
    #2;
    chk("reset_a", {win_a, m_a, cnt_a, st_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // {clr, din, vld, window, match, state, cnt} for dut_a
    add(0,0,1, 4'b0000,0,2'd1,8'd0);
    add(0,1,1, 4'b0001,0,2'd2,8'd0);
    add(0,1,1, 4'b0011,0,2'd3,8'd0);
    add(0,0,1, 4'b0110,1,2'd1,8'd1);
    add(0,1,0, 4'b0110,0,2'd1,8'd1);
    add(0,1,1, 4'b1101,0,2'd2,8'd1);
    add(0,1,1, 4'b1011,0,2'd3,8'd1);
    add(0,0,1, 4'b0110,1,2'd1,8'd2);
    // near-miss 0111 (with the trailing 0 above): ends IDLE
    add(0,1,1, 4'b1101,0,2'd2,8'd2);
    add(0,1,1, 4'b1011,0,2'd3,8'd2);
    add(0,1,1, 4'b0111,0,2'd0,8'd2);
    // near-miss 1110: ends G0
    add(0,1,1, 4'b1111,0,2'd0,8'd2);
    add(0,1,1, 4'b1111,0,2'd0,8'd2);
    add(0,0,1, 4'b1110,0,2'd1,8'd2);
    // near-miss 0100 (reuses trailing 0): ends G0
    add(0,1,1, 4'b1101,0,2'd2,8'd2);
    add(0,0,1, 4'b1010,0,2'd1,8'd2);
    add(0,0,1, 4'b0100,0,2'd1,8'd2);
    // clear priority after 0,1,1 (din=0, valid=1 on the clr edge)
    add(0,1,1, 4'b1001,0,2'd2,8'd2);
    add(0,1,1, 4'b0011,0,2'd3,8'd2);
    add(1,0,1, 4'b0000,0,2'd0,8'd0);
    // 0,1,1,0 with three idle cycles between bits
    add(0,0,1, 4'b0000,0,2'd1,8'd0);
    add(0,1,0, 4'b0000,0,2'd1,8'd0);
    add(0,1,0, 4'b0000,0,2'd1,8'd0);
    add(0,1,0, 4'b0000,0,2'd1,8'd0);
    add(0,1,1, 4'b0001,0,2'd2,8'd0);
    add(0,0,0, 4'b0001,0,2'd2,8'd0);
    add(0,0,0, 4'b0001,0,2'd2,8'd0);
    add(0,0,0, 4'b0001,0,2'd2,8'd0);
    add(0,1,1, 4'b0011,0,2'd3,8'd0);
    add(0,0,0, 4'b0011,0,2'd3,8'd0);
    add(0,0,0, 4'b0011,0,2'd3,8'd0);
    add(0,0,0, 4'b0011,0,2'd3,8'd0);
    add(0,0,1, 4'b0110,1,2'd1,8'd1);
    add(0,0,0, 4'b0110,0,2'd1,8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].din, vecs[i].vld);
      chk($sformatf("vec%0d", i),
          {win_a, m_a, cnt_a, st_a},
          {vecs[i].win, vecs[i].m, vecs[i].cnt, vecs[i].st});
      if (m_a) chk($sformatf("vec%0d_win_on_match", i), win_a, 4'b0110);
    end

    // Overlap vs non-overlap on 0110110.
    do_reset();
    bits7 = 8'b0110_1100;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, bits7[7-i], 1'b1);
      chk($sformatf("ovl_a_m%0d", i), m_a, (i == 3 || i == 6) ? 1'b1 : 1'b0);
      chk($sformatf("ovl_b_m%0d", i), m_b, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("ovl_a_cnt", cnt_a, 8'd2);
    chk("ovl_b_cnt", cnt_b, 8'd1);
    chk("ovl_b_state", st_b, 2'd1);

    // Saturation: 0110 x5 on the 2-bit counter.
    do_reset();
    pat = 4'b0110;
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b0, pat[3-k], 1'b1);
        chk($sformatf("sat_m_r%0d_b%0d", r, k), m_c, (k == 3) ? 1'b1 : 1'b0);
      end
      chk($sformatf("sat_cnt_r%0d", r), cnt_c, exp_c[r]);
    end
    chk("sat_a_cnt", cnt_a, 8'd5);
    chk("sat_b_cnt", cnt_b, 8'd5);

    // Reset mid-pattern: asynchronous effect, then restart from IDLE.
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("mid_pre_state", st_a, 2'd3);
    @(negedge clk);
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_async_rst", {win_a, m_a, cnt_a, st_a}, 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    chk("mid_after_m", m_a, 1'b0);
    chk("mid_after_state", st_a, 2'd1);
    chk("mid_after_win", win_a, 4'b0000);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_after_m2", m_a, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
